// File: rtl/mux_scan_pkg.sv
// Shared types for the N-channel registered mux with auto-scan.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mux_scan_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MANUAL = 2'd1,
        SCAN   = 2'd2
    } state_t;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/scan_sequencer.sv
// Dwell counter and channel index for the scan mode; wraps to channel 0 after the last one.
// Latency: cur_ch moves on the edge where the dwell count reaches DWELL-1.
// Backpressure: none; clr wins over run, both sampled every cycle.
module scan_sequencer #(
    parameter int N_CH  = 8,
    parameter int DWELL = 20,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             run,
    output logic [SEL_W-1:0] cur_ch,
    output logic             advance,
    output logic             last
);

    localparam int               CNT_W   = $clog2(DWELL + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DWELL - 1);
    localparam logic [SEL_W-1:0] CH_MAX  = SEL_W'(N_CH - 1);

    logic [CNT_W-1:0] cnt;

    assign advance = run && (cnt == CNT_MAX);
    assign last    = (cur_ch == CH_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            cur_ch <= '0;
        end else if (clr) begin
            cnt    <= '0;
            cur_ch <= '0;
        end else if (run) begin
            if (advance) begin
                cnt    <= '0;
                // never step past the last real channel
                cur_ch <= last ? '0 : cur_ch + SEL_W'(1);
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/mux_nx1_scan.sv
// N-channel registered mux with manual select or DWELL-cycle auto-scan; MUX_SCAN_CONTINUOUS_EN keeps scanning across passes.
// Latency: 1 cycle from din/sel to dout.
// Backpressure: none; enable low zeroes dout and aborts a scan on the next edge.
module mux_nx1_scan
    import mux_scan_pkg::*;
#(
    parameter int N_CH  = 8,
    parameter int WIDTH = 4,
    parameter int DWELL = 20,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic                  start,
    input  logic [N_CH*WIDTH-1:0] din,
    output logic [WIDTH-1:0]      dout,
    output logic                  dout_valid,
    output logic [SEL_W-1:0]      cur_ch,
    output logic                  busy,
    output logic                  scan_done
);

    state_t state, state_nxt;

    logic [SEL_W-1:0] seq_ch;
    logic             seq_adv;
    logic             seq_last;
    logic             run;
    logic             pass_end;

    logic [WIDTH-1:0] man_dat;
    logic             man_ok;
    logic [WIDTH-1:0] scan_dat;

    logic [WIDTH-1:0] dout_d;
    logic             valid_d;
    logic [SEL_W-1:0] ch_d;

    assign run      = (state == SCAN) && enable;
    assign pass_end = seq_adv && seq_last;

    scan_sequencer #(
        .N_CH  (N_CH),
        .DWELL (DWELL),
        .SEL_W (SEL_W)
    ) u_seq (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (!run),
        .run     (run),
        .cur_ch  (seq_ch),
        .advance (seq_adv),
        .last    (seq_last)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (enable && mode == MODE_MANUAL)
                    state_nxt = MANUAL;
                else if (enable && mode == MODE_SCAN && start)
                    state_nxt = SCAN;
            end
            MANUAL: begin
                if (!enable || mode == MODE_SCAN)
                    state_nxt = IDLE;
            end
            SCAN: begin
                if (!enable) begin
                    state_nxt = IDLE;
                end else if (pass_end) begin
`ifdef MUX_SCAN_CONTINUOUS_EN
                    // mode is only honoured at a pass boundary
                    state_nxt = (mode == MODE_SCAN) ? SCAN : IDLE;
`else
                    state_nxt = IDLE;
`endif
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // select-by-compare keeps sel >= N_CH from ever indexing din
    always_comb begin
        man_dat  = '0;
        man_ok   = 1'b0;
        scan_dat = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (sel == SEL_W'(k)) begin
                man_dat = din[k*WIDTH +: WIDTH];
                man_ok  = 1'b1;
            end
            if (seq_ch == SEL_W'(k))
                scan_dat = din[k*WIDTH +: WIDTH];
        end
    end

    // entering MANUAL loads data on the same edge, so enable/mode changes see 1-cycle latency
    always_comb begin
        dout_d  = '0;
        valid_d = 1'b0;
        ch_d    = '0;
        if (run) begin
            dout_d  = scan_dat;
            valid_d = 1'b1;
            ch_d    = seq_ch;
        end else if (state_nxt == MANUAL && man_ok) begin
            dout_d  = man_dat;
            valid_d = 1'b1;
            ch_d    = sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            dout       <= '0;
            dout_valid <= 1'b0;
            cur_ch     <= '0;
            busy       <= 1'b0;
            scan_done  <= 1'b0;
        end else begin
            state      <= state_nxt;
            dout       <= dout_d;
            dout_valid <= valid_d;
            cur_ch     <= ch_d;
            busy       <= (state_nxt == SCAN);
            scan_done  <= run && pass_end;
        end
    end

endmodule

// File: doc/mux_nx1_scan.md
Name: mux_nx1_scan

Overview:
- Parametrised N-channel, WIDTH-bit registered multiplexer with selectable enable; successor to the fixed 8-input, 4-bit combinational mux.
- Two modes:
  - manual: external select.
  - auto-scan: internal sequencer steps through all channels, holding each for DWELL cycles.
- Sits between multi-source data buses and a single downstream consumer, e.g. a display or serial stage.

Parameters:
- N_CH, 8: number of input channels (2..64).
- WIDTH, 4: bits per channel.
- DWELL, 20: clock cycles each channel is held during scan (>=1).
- SEL_W, $clog2(N_CH): select/channel index width (derived; do not override).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  block enable; low forces output to zero and aborts a scan.
- mode  in  1  0 = manual, 1 = scan.
- sel  in  SEL_W  channel select, manual mode only.
- start  in  1  single-cycle pulse that starts a scan (mode=1, FSM in IDLE).
- din  in  N_CH*WIDTH  flattened inputs; channel k = din[k*WIDTH +: WIDTH].
- dout  out  WIDTH  registered selected data.
- dout_valid  out  1  dout holds a legal channel's data.
- cur_ch  out  SEL_W  channel currently driving dout.
- busy  out  1  high while in SCAN.
- scan_done  out  1  one-cycle pulse after the last channel's dwell completes.

Behaviour:
- Clock and reset:
  - One clock (clk).
  - Reset is asynchronous and active-low (rst_n).
  - On reset: dout=0, dout_valid=0, cur_ch=0, busy=0, scan_done=0, FSM=IDLE, dwell counter=0.
- All outputs are registered. Latency is 1 cycle from input/select change to dout.
- FSM states: IDLE, MANUAL, SCAN.
  - IDLE:
    - enable=1 & mode=0 -> MANUAL.
    - enable=1 & mode=1 & start=1 -> SCAN, with cur_ch=0 and counter=0.
    - Otherwise dout=0, dout_valid=0.
  - MANUAL:
    - Each cycle: dout<=din[sel], cur_ch<=sel, dout_valid<=1.
    - If sel>=N_CH (non-power-of-2 N_CH): dout<=0, dout_valid<=0.
    - enable=0 or mode=1 -> IDLE.
  - SCAN:
    - Each cycle dout<=din[cur_ch], dout_valid<=1, busy=1.
    - Counter increments each cycle. When counter==DWELL-1, the counter clears and cur_ch increments.
    - When cur_ch==N_CH-1 and counter==DWELL-1: scan_done pulses next cycle, FSM -> IDLE, cur_ch -> 0.
- Boundary conditions:
  - start while busy: ignored; start in manual mode: ignored.
  - mode toggles mid-scan: ignored until the scan completes.
  - enable falls mid-scan: FSM -> IDLE next edge, dout=0, dout_valid=0, busy=0, no scan_done, cur_ch -> 0.
  - DWELL=1: channel advances every cycle; a full scan takes exactly N_CH cycles.
  - din changes during a dwell are tracked: dout follows the live input, 1 cycle late.
  - rst_n asserted mid-scan clears everything immediately (asynchronous); no scan_done.
- Width rules:
  - Counter width is $clog2(DWELL+1).
  - cur_ch wrap happens only at N_CH-1; it never indexes beyond N_CH-1.

Optional Feature:
- Macro MUX_SCAN_CONTINUOUS_EN.
- When defined:
  - After the last channel, SCAN wraps to cur_ch=0 instead of returning to IDLE.
  - scan_done still pulses once per completed pass.
  - Scanning continues until enable=0 or mode=0 (mode is sampled only at the pass boundary).
- When undefined: single-pass behaviour exactly as above; the wrap logic is absent.

Decomposition:
- Package mux_scan_pkg:
  - state enum {IDLE, MANUAL, SCAN}.
  - mode constants MODE_MANUAL=1'b0, MODE_SCAN=1'b1.
- Sub-module scan_sequencer, the natural split:
  - Contains the dwell counter plus the channel index/wrap logic.
  - Outputs: cur_ch, advance, last.
- The top level holds the FSM and the registered data path.

Test Plan:
- Manual sweep: N_CH=8, WIDTH=4, din[k]=k, enable=1, mode=0, sel stepped 0..7 every 20 cycles -> dout equals sel one cycle after each change; dout_valid=1 throughout.
- Enable low: mode=0, sel=5, drop enable -> next edge dout=0, dout_valid=0; re-raise enable -> dout=5 after 1 cycle.
- Full scan: din[k]=k, DWELL=20, start pulse -> dout=0 for 20 cycles, then 1, ..., 7; scan_done high exactly 1 cycle, 160 cycles after scan entry; busy low afterwards.
- Abort: start a scan, drop enable at cycle 45 (channel 2) -> IDLE, dout=0, no scan_done; a new start restarts from channel 0.
- Async reset mid-scan: assert rst_n=0 between clock edges -> all outputs 0 immediately, without waiting for clk.
- MUX_SCAN_CONTINUOUS_EN, DWELL=1: start -> dout cycles 0..7,0..7 and onward; scan_done pulses every 8 cycles; mode=0 at the end of a pass -> IDLE.
